// File: rtl/sum_accumulator.sv
// Accumulates a programmable number of adder Sum words into a widened, overflow-free frame total.
// Latency: total is valid the cycle after the last word's edge; one bubble cycle per frame.
// Backpressure: in_ready drops while a total waits in DONE (or clear is high); out_sum/out_count hold until taken.
module sum_accumulator #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+CNT_W-1:0]  out_sum,
    output logic [CNT_W:0]           out_count,
    output logic                     busy
);

    localparam int SUM_W = DATA_W + CNT_W;

    typedef enum logic {ACC, DONE} state_t;

    state_t             state, state_d;
    logic [SUM_W-1:0]   acc, acc_d;
    logic [CNT_W:0]     cnt, cnt_d;
    logic [CNT_W:0]     len_q, len_q_d;
    logic [CNT_W:0]     len_ext, len_eff, cnt_inc;
    logic               take;

    // len==0 encodes a full 2^CNT_W frame: the extra MSB is set only in that case
    assign len_ext = {(len == '0), len};
    assign len_eff = (cnt == '0) ? len_ext : len_q;
    assign cnt_inc = cnt + (CNT_W+1)'(1);

    assign in_ready  = rst_n && (state == ACC) && !clear;
    assign take      = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC) && (cnt != '0);
    assign out_sum   = acc;
    assign out_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            len_q <= len_q_d;
        end
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        len_q_d = len_q;
        if (clear) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                ACC: begin
                    if (take) begin
                        acc_d = acc + {{CNT_W{1'b0}}, in_data};
                        cnt_d = cnt_inc;
                        if (cnt == '0)
                            len_q_d = len_ext;
                        if (cnt_inc == len_eff)
                            state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

endmodule
